// File: rtl/mul_dispatch.sv
// Operand FIFO plus single-outstanding issue FSM feeding a cumulative shift-add multiplier.
// Product appears MUL_LAT+1 cycles after the issue pulse and is held until out_ready; in_ready drops when full or recovering.
module mul_dispatch #(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        mul_valid,
  output logic [15:0] mul_num1,
  output logic [15:0] mul_num2,
  input  logic [31:0] mul_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_product,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [LW-1:0] LAST = LW'(MUL_LAT - 1);

  localparam logic [2:0] S_RECOVER = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [15:0]   num1_q, num1_d;
  logic [15:0]   num2_q, num2_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   prod_q, prod_d;
  logic          out_vld_q, out_vld_d;

  logic          push;
  logic          pop;
  logic [31:0]   head;

  assign in_ready    = (state_q != S_RECOVER) && (count_q < FULL);
  assign push        = in_valid && in_ready;
  assign pop         = (state_q == S_ISSUE);
  assign head        = mem_q[rd_ptr_q];

  assign mul_valid   = (state_q == S_ISSUE);
  assign mul_num1    = num1_q;
  assign mul_num2    = num2_q;
  assign out_valid   = out_vld_q;
  assign out_product = prod_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // The multiplier accumulator is never cleared, so each product is the delta from base.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    base_d    = base_q;
    prod_d    = prod_q;
    out_vld_d = out_vld_q;
    case (state_q)
      S_RECOVER: begin
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_ISSUE;
          num1_d  = head[31:16];
          num2_d  = head[15:0];
        end
      end
      S_ISSUE: begin
        base_d  = mul_result;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAST) begin
          prod_d    = mul_result - base_q;
          out_vld_d = 1'b1;
          state_d   = S_OUT;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_RECOVER;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_RECOVER;
      cnt_q     <= '0;
      num1_q    <= '0;
      num2_q    <= '0;
      base_q    <= '0;
      prod_q    <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      base_q    <= base_d;
      prod_q    <= prod_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule
